// File: rtl/euler_angle_matrix_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : euler_angle_matrix_gen_if
// Purpose  : Angle-triple inputs and 4x4 rotation-matrix output bundle.
// Revision : 1.0
// ============================================================================
interface euler_angle_matrix_gen_if;
    logic [11:0]       alpha;
    logic [11:0]       beta;
    logic [11:0]       gamma;
    logic [15:0][13:0] euler_angle_matrix;

    modport master (output alpha, beta, gamma, input euler_angle_matrix);
    modport slave  (input alpha, beta, gamma, output euler_angle_matrix);
endinterface
`default_nettype wire

// File: rtl/euler_angle_matrix_gen.sv
`default_nettype none
// ============================================================================
// Module   : euler_angle_matrix_gen
// Purpose  : Q4.8 Euler angles -> Q2.12 Rz(g)*Ry(b)*Rx(a) matrix, 3-stage pipe.
// Revision : 1.0
// ============================================================================
module euler_angle_matrix_gen #(
    parameter int LATENCY = 3
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    euler_angle_matrix_gen_if.slave bus
);
    // Angle constants carry 16 fraction bits so reduction error stays far below 1 LSB.
    localparam logic signed [21:0] TWO_PI   = 22'sd411775;
    localparam logic signed [21:0] PI       = 22'sd205887;
    localparam logic signed [21:0] HALF_PI  = 22'sd102944;
    localparam logic signed [21:0] CORDIC_K = 22'sd39797;
    localparam logic signed [13:0] ONE_Q12  = 14'sd4096;
    localparam logic signed [21:0] ATAN [12] = '{
        22'sd51472, 22'sd30386, 22'sd16055, 22'sd8150, 22'sd4091, 22'sd2047,
        22'sd1024,  22'sd512,   22'sd256,   22'sd128,  22'sd64,   22'sd32
    };

    function automatic logic [22:0] reduce_fold(input logic [11:0] ang);
        logic signed [21:0] r;
        logic               neg;
        r = {{2{ang[11]}}, ang, 8'b0};
        for (int k = 0; k < 2; k++) begin
            if (r >= PI)       r = r - TWO_PI;
            else if (r < -PI)  r = r + TWO_PI;
        end
        neg = 1'b0;
        if (r > HALF_PI) begin
            r   = PI - r;
            neg = 1'b1;
        end else if (r < -HALF_PI) begin
            r   = -PI - r;
            neg = 1'b1;
        end
        return {neg, r};
    endfunction

    function automatic logic signed [13:0] to_q12(input logic signed [21:0] v);
        logic signed [21:0] r;
        r = (v + 22'sd8) >>> 4;
        if (r > 22'sd4096)       r = 22'sd4096;
        else if (r < -22'sd4096) r = -22'sd4096;
        return 14'(r);
    endfunction

    function automatic logic [27:0] sin_cos(input logic signed [21:0] ang, input logic neg);
        logic signed [21:0] x, y, z, xt, xc, yc;
        logic signed [43:0] pxz, pyz;
        logic signed [13:0] s, c;
        x = CORDIC_K;
        y = '0;
        z = ang;
        for (int i = 0; i < 12; i++) begin
            xt = x;
            if (!z[21]) begin
                x = x - (y >>> i);
                y = y + (xt >>> i);
                z = z - ATAN[i];
            end else begin
                x = x + (y >>> i);
                y = y - (xt >>> i);
                z = z + ATAN[i];
            end
        end
        // First-order rotation by the leftover angle removes the last-iteration residual.
        pxz = 44'(x) * 44'(z);
        pyz = 44'(y) * 44'(z);
        yc  = y + 22'(pxz >>> 16);
        xc  = x - 22'(pyz >>> 16);
        s   = to_q12(yc);
        c   = to_q12(xc);
        if (neg) c = -c;
        return {s, c};
    endfunction

    function automatic logic signed [13:0] mul_q12(input logic signed [13:0] a,
                                                   input logic signed [13:0] b);
        logic signed [27:0] p;
        p = 28'(a) * 28'(b) + 28'sd2048;
        return 14'(p >>> 12);
    endfunction

    function automatic logic signed [13:0] sat_add(input logic signed [13:0] a,
                                                   input logic signed [13:0] b);
        logic signed [14:0] s;
        s = 15'(a) + 15'(b);
        if (s > 15'sd4096)       s = 15'sd4096;
        else if (s < -15'sd4096) s = -15'sd4096;
        return 14'(s);
    endfunction

    logic [11:0]        ang_in [3];
    logic signed [21:0] ang_d  [3];
    logic signed [21:0] ang_q  [3];
    logic [2:0]         neg_d, neg_q;
    logic signed [13:0] sin_d  [3];
    logic signed [13:0] cos_d  [3];
    logic signed [13:0] sin_q  [3];
    logic signed [13:0] cos_q  [3];
    logic [LATENCY-2:0] valid_q;
    logic [15:0][13:0]  mat_d, mat_q;
    logic signed [13:0] ca, sa, cb, sb, cg, sg, sab, cab;

    assign ang_in[0] = bus.alpha;
    assign ang_in[1] = bus.beta;
    assign ang_in[2] = bus.gamma;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            {neg_d[k], ang_d[k]} = reduce_fold(ang_in[k]);
            {sin_d[k], cos_d[k]} = sin_cos(ang_q[k], neg_q[k]);
        end
    end

    assign ca = cos_q[0];
    assign sa = sin_q[0];
    assign cb = cos_q[1];
    assign sb = sin_q[1];
    assign cg = cos_q[2];
    assign sg = sin_q[2];

    always_comb begin
        sab   = mul_q12(sa, sb);
        cab   = mul_q12(ca, sb);
        mat_d = '0;
        if (valid_q[LATENCY-2]) begin
            mat_d[0]  = mul_q12(cb, cg);
            mat_d[1]  = sat_add(mul_q12(sab, cg), -mul_q12(ca, sg));
            mat_d[2]  = sat_add(mul_q12(cab, cg), mul_q12(sa, sg));
            mat_d[4]  = mul_q12(cb, sg);
            mat_d[5]  = sat_add(mul_q12(sab, sg), mul_q12(ca, cg));
            mat_d[6]  = sat_add(mul_q12(cab, sg), -mul_q12(sa, cg));
            mat_d[8]  = -sb;
            mat_d[9]  = mul_q12(sa, cb);
            mat_d[10] = mul_q12(ca, cb);
            mat_d[15] = ONE_Q12;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ang_q   <= '{default: '0};
            neg_q   <= '0;
            sin_q   <= '{default: '0};
            cos_q   <= '{default: '0};
            valid_q <= '0;
            mat_q   <= '0;
        end else begin
            ang_q   <= ang_d;
            neg_q   <= neg_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            valid_q <= {valid_q[LATENCY-3:0], 1'b1};
            mat_q   <= mat_d;
        end
    end

    assign bus.euler_angle_matrix = mat_q;
endmodule
`default_nettype wire

// File: tb/tb_euler_angle_matrix_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_euler_angle_matrix_gen
// Purpose  : Self-checking bench against a double-precision rotation model.
// Revision : 1.0
// ============================================================================
module tb_euler_angle_matrix_gen;
    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    euler_angle_matrix_gen_if bus ();

    euler_angle_matrix_gen #(.LATENCY(3)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Ideal element (row*4+col) of Rz(g)*Ry(b)*Rx(a), rounded to Q2.12 integer units.
    function automatic int ideal(input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] g, input int e);
        real ca, sa, cb, sb, cg, sg, v;
        ca = $cos(real'($signed(a)) / 256.0);
        sa = $sin(real'($signed(a)) / 256.0);
        cb = $cos(real'($signed(b)) / 256.0);
        sb = $sin(real'($signed(b)) / 256.0);
        cg = $cos(real'($signed(g)) / 256.0);
        sg = $sin(real'($signed(g)) / 256.0);
        case (e)
            0:       v = cb * cg;
            1:       v = sa * sb * cg - ca * sg;
            2:       v = ca * sb * cg + sa * sg;
            4:       v = cb * sg;
            5:       v = sa * sb * sg + ca * cg;
            6:       v = ca * sb * sg - sa * cg;
            8:       v = -sb;
            9:       v = sa * cb;
            10:      v = ca * cb;
            15:      v = 1.0;
            default: v = 0.0;
        endcase
        return int'($floor(v * 4096.0 + 0.5));
    endfunction

    function automatic int tol(input int e);
        return (e == 3 || e == 7 || e >= 11) ? 0 : 6;
    endfunction

    function automatic int elem(input int e);
        return int'($signed(bus.euler_angle_matrix[e]));
    endfunction

    task automatic test_reset();
        int act, exp;
        @(negedge Clk);
        Reset = 1'b1;
        bus.alpha = '0;
        bus.beta  = '0;
        bus.gamma = '0;
        repeat (2) begin
            @(posedge Clk); #1;
            for (int e = 0; e < 16; e++) begin
                act = elem(e);
                checks++;
                if (act !== 0) begin
                    failures++;
                    $display("FAIL reset_hold elem=%0d got=%0d want=0", e, act);
                end
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        for (int e = 0; e < 16; e++) begin
            act = elem(e);
            exp = ideal(12'h0, 12'h0, 12'h0, e);
            checks++;
            if (act > exp + tol(e) || act < exp - tol(e)) begin
                failures++;
                $display("FAIL reset_identity elem=%0d got=%0d want=%0d", e, act, exp);
            end
        end
    endtask

    task automatic test_directed();
        logic [11:0] ta [6] = '{12'h181, 12'h000, 12'h000, 12'h000, 12'h000, 12'h7FF};
        logic [11:0] tb [6] = '{12'h286, 12'h192, 12'h000, 12'h000, 12'h000, 12'h800};
        logic [11:0] tg [6] = '{12'h345, 12'h000, 12'h324, 12'h800, 12'hCDC, 12'h400};
        int act, exp;
        for (int v = 0; v < 6; v++) begin
            @(negedge Clk);
            bus.alpha = ta[v];
            bus.beta  = tb[v];
            bus.gamma = tg[v];
            repeat (3) @(posedge Clk);
            #1;
            for (int e = 0; e < 16; e++) begin
                act = elem(e);
                exp = ideal(ta[v], tb[v], tg[v], e);
                checks++;
                if (act > exp + tol(e) || act < exp - tol(e)) begin
                    failures++;
                    $display("FAIL directed vec=%0d elem=%0d got=%0d want=%0d", v, e, act, exp);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic [11:0] ha [64];
        logic [11:0] hb [64];
        logic [11:0] hg [64];
        bit          hr [64];
        bit          valid;
        int          act, exp, t;
        for (int c = 0; c < 64; c++) begin
            @(negedge Clk);
            hr[c] = (c == 0);
            ha[c] = 12'($urandom);
            hb[c] = 12'($urandom);
            hg[c] = 12'($urandom);
            Reset     = hr[c];
            bus.alpha = ha[c];
            bus.beta  = hb[c];
            bus.gamma = hg[c];
            @(posedge Clk); #1;
            valid = (c >= 2) && !hr[c] && !hr[c-1] && !hr[c-2];
            for (int e = 0; e < 16; e++) begin
                act = elem(e);
                exp = valid ? ideal(ha[c-2], hb[c-2], hg[c-2], e) : 0;
                t   = valid ? tol(e) : 0;
                checks++;
                if (act > exp + t || act < exp - t) begin
                    failures++;
                    $display("FAIL random_stream cyc=%0d elem=%0d got=%0d want=%0d", c, e, act, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ha [24];
        logic [11:0] hb [24];
        logic [11:0] hg [24];
        bit          hr [24];
        bit          valid;
        int          act, exp, t;
        for (int c = 0; c < 24; c++) begin
            @(negedge Clk);
            hr[c] = (c == 0) || (c == 10);
            ha[c] = 12'(c * 97 + 12'h0A5);
            hb[c] = 12'(12'h9C3 - c * 151);
            hg[c] = 12'($urandom);
            Reset     = hr[c];
            bus.alpha = ha[c];
            bus.beta  = hb[c];
            bus.gamma = hg[c];
            @(posedge Clk); #1;
            valid = (c >= 2) && !hr[c] && !hr[c-1] && !hr[c-2];
            for (int e = 0; e < 16; e++) begin
                act = elem(e);
                exp = valid ? ideal(ha[c-2], hb[c-2], hg[c-2], e) : 0;
                t   = valid ? tol(e) : 0;
                checks++;
                if (act > exp + t || act < exp - t) begin
                    failures++;
                    $display("FAIL back_to_back cyc=%0d elem=%0d got=%0d want=%0d", c, e, act, exp);
                end
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        bus.alpha = '0;
        bus.beta  = '0;
        bus.gamma = '0;
        test_reset();
        test_directed();
        test_random_stream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
